usb_rx_nrzi_decoder: RTL and testbench
======================================

// Module: usb_rx_nrzi_decoder
// PURPOSE
//  Receive-side counterpart of the NN_TX NRZI encode/bit-stuff path. Samples synchronised D+/D-,
//  recovers bit timing with an edge-resynchronised bit counter, NRZI-decodes, strips stuffed bits,
//  removes SYNC, assembles bytes LSB-first and flags EOP. Feeds the RX packet FSM / byte FIFO.
// PARAMETERS
//  CLKS_PER_BIT  8  clk cycles per USB bit time (bit counter rollover value)
//  SAMPLE_POINT  3  bit-counter value at which the line is sampled (0..CLKS_PER_BIT-1)
//  STUFF_LIMIT   6  consecutive decoded 1s after which one stuffed 0 is expected
// PORTS
//  clk          in   1  system clock
//  n_rst        in   1  async active-low reset
//  d_plus_sync  in   1  D+ already 2-FF synchronised
//  d_minus_sync in   1  D- already 2-FF synchronised
//  rx_enable    in   1  arm receiver; checked only in IDLE
//  rx_data      out  8  last assembled byte, LSB = first bit received
//  byte_valid   out  1  1-cycle pulse, rx_data valid
//  eop          out  1  1-cycle pulse, end of packet detected
//  stuff_err    out  1  1-cycle pulse, bit-stuff violation
//  receiving    out  1  high from SYNC detect through EOP/abort
// BEHAVIOUR
//  Reset (async, n_rst=0): rx_data=8'h00, byte_valid=0, eop=0, stuff_err=0, receiving=0, FSM=IDLE,
//   prev_level=J (1), ones_cnt=0, bit_cnt=0, bit timer=0. Reset mid-packet aborts silently, no pulses.
//  Line states: J = (D+,D-)=(1,0); K = (0,1); SE0 = (0,0); (1,1) treated as SE0.
//  Bit timer: counts 0..CLKS_PER_BIT-1 and wraps; forced to 0 on any D+ change (edge resync).
//   Sample strobe when timer==SAMPLE_POINT; exactly one sample per bit time.
//  NRZI: decoded bit = 1 if sampled level == prev_level, else 0; prev_level updated every sample.
//  FSM states:
//   IDLE    - timer idle. rx_enable && J->K transition -> SYNC (timer cleared, prev_level=J).
//   SYNC    - shift decoded bits; on decoded pattern 0,0,0,0,0,0,0,1 (KJKJKJKK) -> DATA, receiving=1,
//             ones_cnt=1, bit_cnt=0. SE0 sample or 16 samples without match -> IDLE (no pulses).
//   DATA    - decoded 1: ones_cnt++; shift in. decoded 0: if ones_cnt==STUFF_LIMIT discard (stuffed
//             bit), else shift in; ones_cnt=0. Shifted bit enters rx_data MSB side (shift right),
//             bit_cnt++; at bit_cnt==8 -> byte_valid pulse next cycle, bit_cnt=0.
//             SE0 sample -> EOP_WAIT; partial byte (bit_cnt!=0) discarded, no byte_valid.
//   EOP_WAIT- J sample -> eop pulse, receiving=0, IDLE. K sample -> stuff_err pulse, ABORT.
//   ABORT   - receiving=0; wait for SE0 then J, -> IDLE, no eop pulse.
//  Latency: byte_valid/eop/stuff_err asserted the cycle after the deciding sample strobe.
//  rx_data holds its value until next byte completes; not cleared at EOP.
//  Byte completion and SE0 on same sample: SE0 wins (byte not yet complete cannot coexist).
//  ones_cnt saturates at STUFF_LIMIT+1; resets to 0 on EOP/IDLE.
//  rx_enable deassert while in SYNC/DATA ignored; packet completes normally.
// CONFIGURATION
//  USB_RX_STUFF_CHECK_EN defined: in DATA, decoded 1 while ones_cnt==STUFF_LIMIT (i.e. 7th 1)
//   -> stuff_err pulse, receiving=0, ABORT.
//  Not defined: stuff_err tied 0; 7th consecutive 1 is treated as the stuffed bit and discarded;
//   reception continues.
// TESTING (CLKS_PER_BIT=8, SAMPLE_POINT=3)
//  1 Reset mid-DATA: assert n_rst=0 at byte 1 bit 4 -> all outputs 0 immediately, FSM IDLE, no pulses.
//  2 SYNC + bytes 0xA5,0x3C + SE0 SE0 J -> byte_valid x2 with rx_data=8'hA5 then 8'h3C; eop 1 pulse
//    one clk after J sample; receiving low same cycle.
//  3 Byte 0xFF,0x7F (stuffed 0 after six 1s) -> rx_data=8'hFF,8'h7F; stuffed bits not counted.
//  4 With USB_RX_STUFF_CHECK_EN: seven raw 1s -> stuff_err 1 pulse, no byte_valid, receiving=0;
//    then SE0,J -> IDLE, no eop. Without macro: stuff_err stays 0.
//  5 Edge jitter: shift every K/J transition +-2 clks -> identical bytes as test 2.
//  6 SE0 after 3 data bits -> no byte_valid, eop pulse; rx_enable=0 at J->K -> stays IDLE.

Source files
------------

// File: rtl/usb_rx_nrzi_decoder.sv
// USB receive front end: edge-resynchronised bit timing, NRZI decode, bit de-stuffing, SYNC strip,
// LSB-first byte assembly and EOP detection. Define USB_RX_STUFF_CHECK_EN to abort on stuff violations.
module usb_rx_nrzi_decoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 3,
  parameter int STUFF_LIMIT  = 6
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus_sync,
  input  logic       d_minus_sync,
  input  logic       rx_enable,
  output logic [7:0] rx_data,
  output logic       byte_valid,
  output logic       eop,
  output logic       stuff_err,
  output logic       receiving
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int OW = $clog2(STUFF_LIMIT + 2);

  localparam logic [TW-1:0] TIMER_LAST   = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TIMER_SAMPLE = TW'(SAMPLE_POINT);
  localparam logic [OW-1:0] ONES_STUFF   = OW'(STUFF_LIMIT);
  localparam logic [OW-1:0] ONES_SAT     = OW'(STUFF_LIMIT + 1);
  localparam logic [7:0]    SYNC_MATCH   = 8'h01;
  localparam logic [3:0]    SYNC_TIMEOUT = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_EOP_WAIT,
    S_ABORT
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            dp_last_q, dp_last_d;
  logic            dm_last_q, dm_last_d;
  logic            prev_level_q, prev_level_d;
  logic [OW-1:0]   ones_cnt_q, ones_cnt_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      sync_sr_q, sync_sr_d;
  logic            se0_seen_q, se0_seen_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            byte_valid_q, byte_valid_d;
  logic            eop_q, eop_d;
  logic            receiving_q, receiving_d;
`ifdef USB_RX_STUFF_CHECK_EN
  logic            stuff_err_q, stuff_err_d;
`endif

  logic       line_j, line_k, line_se0, last_j;
  logic       dp_edge, sample, dec_bit, shift_en;
  logic [7:0] sync_next, data_next;

  assign line_j    = d_plus_sync & ~d_minus_sync;
  assign line_k    = ~d_plus_sync & d_minus_sync;
  assign line_se0  = ~(line_j | line_k);
  assign last_j    = dp_last_q & ~dm_last_q;
  assign dp_edge   = d_plus_sync ^ dp_last_q;
  assign sample    = (state_q != S_IDLE) && (timer_q == TIMER_SAMPLE);
  assign dec_bit   = (d_plus_sync == prev_level_q);
  assign sync_next = {sync_sr_q[6:0], dec_bit};
  assign data_next = {dec_bit, shift_q[7:1]};

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    state_d      = state_q;
    dp_last_d    = d_plus_sync;
    dm_last_d    = d_minus_sync;
    prev_level_d = prev_level_q;
    ones_cnt_d   = ones_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    sync_sr_d    = sync_sr_q;
    se0_seen_d   = se0_seen_q;
    rx_data_d    = rx_data_q;
    byte_valid_d = 1'b0;
    eop_d        = 1'b0;
    receiving_d  = receiving_q;
    shift_en     = 1'b0;
`ifdef USB_RX_STUFF_CHECK_EN
    stuff_err_d  = 1'b0;
`endif

    // Free-running bit timer, pulled back to zero on every D+ transition.
    if (state_q == S_IDLE || dp_edge || timer_q == TIMER_LAST) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        ones_cnt_d   = '0;
        prev_level_d = 1'b1;
        if (rx_enable && last_j && line_k) begin
          state_d   = S_SYNC;
          sync_sr_d = 8'hFF;
          bit_cnt_d = '0;
          timer_d   = '0;
        end
      end

      S_SYNC: begin
        if (sample) begin
          prev_level_d = d_plus_sync;
          if (line_se0) begin
            state_d = S_IDLE;
          end else begin
            sync_sr_d = sync_next;
            if (sync_next == SYNC_MATCH) begin
              state_d     = S_DATA;
              receiving_d = 1'b1;
              ones_cnt_d  = OW'(1);
              bit_cnt_d   = '0;
            end else if (bit_cnt_q == SYNC_TIMEOUT) begin
              state_d = S_IDLE;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
      end

      S_DATA: begin
        if (sample) begin
          prev_level_d = d_plus_sync;
          if (line_se0) begin
            state_d   = S_EOP_WAIT;
            bit_cnt_d = '0;
          end else if (dec_bit) begin
            if (ones_cnt_q == ONES_STUFF) begin
`ifdef USB_RX_STUFF_CHECK_EN
              stuff_err_d = 1'b1;
              receiving_d = 1'b0;
              se0_seen_d  = 1'b0;
              state_d     = S_ABORT;
`else
              // Seventh 1 stands in for the missing stuffed 0 and is dropped.
              ones_cnt_d  = ONES_SAT;
`endif
            end else begin
              shift_en   = 1'b1;
              ones_cnt_d = (ones_cnt_q == ONES_SAT) ? ONES_SAT : ones_cnt_q + OW'(1);
            end
          end else begin
            shift_en   = (ones_cnt_q != ONES_STUFF);
            ones_cnt_d = '0;
          end

          if (shift_en) begin
            shift_d = data_next;
            if (bit_cnt_q == 4'd7) begin
              rx_data_d    = data_next;
              byte_valid_d = 1'b1;
              bit_cnt_d    = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
      end

      S_EOP_WAIT: begin
        if (sample) begin
          if (line_j) begin
            eop_d       = 1'b1;
            receiving_d = 1'b0;
            state_d     = S_IDLE;
          end else if (line_k) begin
`ifdef USB_RX_STUFF_CHECK_EN
            stuff_err_d = 1'b1;
`endif
            receiving_d = 1'b0;
            se0_seen_d  = 1'b0;
            state_d     = S_ABORT;
          end
        end
      end

      S_ABORT: begin
        receiving_d = 1'b0;
        if (sample) begin
          if (line_se0) begin
            se0_seen_d = 1'b1;
          end else if (line_j && se0_seen_q) begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
    if (!n_rst) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      dp_last_q    <= 1'b1;
      dm_last_q    <= 1'b0;
      prev_level_q <= 1'b1;
      ones_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      sync_sr_q    <= 8'hFF;
      se0_seen_q   <= 1'b0;
      rx_data_q    <= '0;
      byte_valid_q <= 1'b0;
      eop_q        <= 1'b0;
      receiving_q  <= 1'b0;
`ifdef USB_RX_STUFF_CHECK_EN
      stuff_err_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      dp_last_q    <= dp_last_d;
      dm_last_q    <= dm_last_d;
      prev_level_q <= prev_level_d;
      ones_cnt_q   <= ones_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      sync_sr_q    <= sync_sr_d;
      se0_seen_q   <= se0_seen_d;
      rx_data_q    <= rx_data_d;
      byte_valid_q <= byte_valid_d;
      eop_q        <= eop_d;
      receiving_q  <= receiving_d;
`ifdef USB_RX_STUFF_CHECK_EN
      stuff_err_q  <= stuff_err_d;
`endif
    end
  end

  assign rx_data    = rx_data_q;
  assign byte_valid = byte_valid_q;
  assign eop        = eop_q;
  assign receiving  = receiving_q;
`ifdef USB_RX_STUFF_CHECK_EN
  assign stuff_err  = stuff_err_q;
`else
  assign stuff_err  = 1'b0;
`endif

endmodule

// File: tb/tb_usb_rx_nrzi_decoder.sv
// Directed bench for usb_rx_nrzi_decoder: builds NRZI line waveforms from bytes and checks the
// recovered bytes, EOP/stuff pulses and timing against hand-computed expectations.
module tb_usb_rx_nrzi_decoder;

  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LK   = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       d_plus;
  logic       d_minus;
  logic       rx_enable;
  logic [7:0] rx_data;
  logic       byte_valid;
  logic       eop;
  logic       stuff_err;
  logic       receiving;

  int vectors     = 0;
  int miscompares = 0;

  // Monitor-owned observations
  int         cyc        = 0;
  int         eop_cnt    = 0;
  int         serr_cnt   = 0;
  int         eop_cyc    = 0;
  int         rcv_cycles = 0;
  logic       eop_rcv    = 1'b1;
  logic [7:0] got_q[$];

  // Stimulus-owned state
  int         j_cyc = 0;
  logic [1:0] lvq[$];
  logic       cur_lvl;
  int         ones;
  int         off_tab[8] = '{1, 2, 1, 0, -1, -2, -1, 0};

  usb_rx_nrzi_decoder #(
    .CLKS_PER_BIT(8),
    .SAMPLE_POINT(3),
    .STUFF_LIMIT (6)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .d_plus_sync (d_plus),
    .d_minus_sync(d_minus),
    .rx_enable   (rx_enable),
    .rx_data     (rx_data),
    .byte_valid  (byte_valid),
    .eop         (eop),
    .stuff_err   (stuff_err),
    .receiving   (receiving)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (n_rst) begin
      if (byte_valid) got_q.push_back(rx_data);
      if (eop) begin
        eop_cnt = eop_cnt + 1;
        eop_cyc = cyc;
        eop_rcv = receiving;
      end
      if (stuff_err) serr_cnt = serr_cnt + 1;
      if (receiving) rcv_cycles = rcv_cycles + 1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: run did not finish, vectors=%0d", vectors);
    $fatal(1);
  end

  // ---------------- waveform construction ----------------
  task automatic q_clear();
    lvq.delete();
    cur_lvl = 1'b1;
    ones    = 0;
  endtask

  task automatic q_bit(input logic b);
    if (!b) cur_lvl = ~cur_lvl;
    lvq.push_back(cur_lvl ? LJ : LK);
  endtask

  task automatic q_sync();
    for (int i = 0; i < 7; i++) q_bit(1'b0);
    q_bit(1'b1);
    ones = 1;
  endtask

  task automatic q_data(input logic b, input bit stuff);
    q_bit(b);
    if (b) ones = ones + 1;
    else   ones = 0;
    if (stuff && ones == 6) begin
      q_bit(1'b0);
      ones = 0;
    end
  endtask

  task automatic q_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) q_data(v[i], 1'b1);
  endtask

  task automatic q_eop();
    lvq.push_back(LSE0);
    lvq.push_back(LSE0);
    lvq.push_back(LJ);
  endtask

  task automatic drive(input logic [1:0] ln, input int clks);
    {d_plus, d_minus} = ln;
    repeat (clks) @(negedge clk);
  endtask

  // Plays lvq; jit shifts each transition by off_tab. cut>=0 stops 4 clks into bit 'cut'.
  task automatic play(input bit jit, input int cut);
    int n;
    int t;
    int bo[$];
    n = lvq.size();
    t = 0;
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        bo.push_back(jit ? off_tab[0] : 0);
        t = 1;
      end else if (lvq[i] != lvq[i-1]) begin
        bo.push_back(jit ? off_tab[t % 8] : 0);
        t = t + 1;
      end else begin
        bo.push_back(bo[i-1]);
      end
    end
    drive(LJ, 10 + bo[0]);
    for (int i = 0; i < n - 1; i++) begin
      if (i == cut) begin
        drive(lvq[i], 4);
        return;
      end
      drive(lvq[i], 8 + bo[i+1] - bo[i]);
    end
    {d_plus, d_minus} = lvq[n-1];
    #1 j_cyc = cyc;
    repeat (20) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_rst = 1'b0;
    rx_enable = 1'b1;
    {d_plus, d_minus} = LJ;
    repeat (3) @(negedge clk);
    vectors++;
    if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    vectors++;
    if ({byte_valid, eop, stuff_err, receiving} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got bv/eop/se/rcv=%b want 0000", {byte_valid, eop, stuff_err, receiving});
    end
    n_rst = 1'b1;
    repeat (20) @(negedge clk);
    vectors++;
    if (receiving !== 1'b0) begin miscompares++; $display("FAIL reset_idle_rcv: got %b want 0", receiving); end
  endtask

  task automatic run_a5_3c(input bit jit, input string tag);
    int b0, e0, r0;
    b0 = got_q.size();
    e0 = eop_cnt;
    r0 = rcv_cycles;
    q_clear();
    q_sync();
    q_byte(8'hA5);
    q_byte(8'h3C);
    q_eop();
    play(jit, -1);
    vectors++;
    if (got_q.size() - b0 != 2) begin
      miscompares++;
      $display("FAIL %s_byte_count: got %0d want 2", tag, got_q.size() - b0);
    end
    if (got_q.size() >= b0 + 2) begin
      vectors++;
      if (got_q[b0] !== 8'hA5) begin miscompares++; $display("FAIL %s_byte0: got %h want a5", tag, got_q[b0]); end
      vectors++;
      if (got_q[b0+1] !== 8'h3C) begin miscompares++; $display("FAIL %s_byte1: got %h want 3c", tag, got_q[b0+1]); end
    end
    vectors++;
    if (eop_cnt - e0 != 1) begin miscompares++; $display("FAIL %s_eop_count: got %0d want 1", tag, eop_cnt - e0); end
    vectors++;
    if (eop_cyc - j_cyc != 5) begin miscompares++; $display("FAIL %s_eop_latency: got %0d want 5", tag, eop_cyc - j_cyc); end
    vectors++;
    if (eop_rcv !== 1'b0) begin miscompares++; $display("FAIL %s_rcv_at_eop: got %b want 0", tag, eop_rcv); end
    vectors++;
    if (rcv_cycles - r0 < 100) begin miscompares++; $display("FAIL %s_rcv_active: got %0d cycles want >=100", tag, rcv_cycles - r0); end
    vectors++;
    if (rx_data !== 8'h3C) begin miscompares++; $display("FAIL %s_rx_data_hold: got %h want 3c", tag, rx_data); end
  endtask

  task automatic test_two_bytes();
    run_a5_3c(1'b0, "basic");
  endtask

  task automatic test_stuffed_bytes();
    int b0, e0;
    b0 = got_q.size();
    e0 = eop_cnt;
    q_clear();
    q_sync();
    q_byte(8'hFF);
    q_byte(8'h7F);
    q_eop();
    play(1'b0, -1);
    vectors++;
    if (got_q.size() - b0 != 2) begin
      miscompares++;
      $display("FAIL stuffed_byte_count: got %0d want 2", got_q.size() - b0);
    end
    if (got_q.size() >= b0 + 2) begin
      vectors++;
      if (got_q[b0] !== 8'hFF) begin miscompares++; $display("FAIL stuffed_byte0: got %h want ff", got_q[b0]); end
      vectors++;
      if (got_q[b0+1] !== 8'h7F) begin miscompares++; $display("FAIL stuffed_byte1: got %h want 7f", got_q[b0+1]); end
    end
    vectors++;
    if (eop_cnt - e0 != 1) begin miscompares++; $display("FAIL stuffed_eop_count: got %0d want 1", eop_cnt - e0); end
  endtask

  task automatic test_reset_mid_data();
    int b0, e0, s0, r0;
    b0 = got_q.size();
    e0 = eop_cnt;
    s0 = serr_cnt;
    q_clear();
    q_sync();
    q_byte(8'hA5);
    q_eop();
    play(1'b0, 12);
    vectors++;
    if (receiving !== 1'b1) begin miscompares++; $display("FAIL midrst_rcv_before: got %b want 1", receiving); end
    #1 n_rst = 1'b0;
    #1;
    vectors++;
    if (rx_data !== 8'h00) begin miscompares++; $display("FAIL midrst_rx_data: got %h want 00", rx_data); end
    vectors++;
    if ({byte_valid, eop, stuff_err, receiving} !== 4'b0000) begin
      miscompares++;
      $display("FAIL midrst_flags: got bv/eop/se/rcv=%b want 0000", {byte_valid, eop, stuff_err, receiving});
    end
    repeat (3) @(negedge clk);
    {d_plus, d_minus} = LJ;
    @(negedge clk);
    n_rst = 1'b1;
    r0 = rcv_cycles;
    repeat (60) @(negedge clk);
    vectors++;
    if ((got_q.size() - b0) + (eop_cnt - e0) + (serr_cnt - s0) != 0) begin
      miscompares++;
      $display("FAIL midrst_pulses: got bytes=%0d eop=%0d serr=%0d want 0", got_q.size() - b0, eop_cnt - e0, serr_cnt - s0);
    end
    vectors++;
    if (rcv_cycles - r0 != 0) begin miscompares++; $display("FAIL midrst_rcv_after: got %0d cycles want 0", rcv_cycles - r0); end
  endtask

  task automatic test_stuff_violation();
    int b0, e0, s0;
    b0 = got_q.size();
    e0 = eop_cnt;
    s0 = serr_cnt;
    q_clear();
    q_sync();
    for (int i = 0; i < 7; i++) q_data(1'b1, 1'b0);
    q_eop();
    play(1'b0, -1);
    vectors++;
    if (got_q.size() - b0 != 0) begin miscompares++; $display("FAIL stuffviol_bytes: got %0d want 0", got_q.size() - b0); end
    vectors++;
    if (receiving !== 1'b0) begin miscompares++; $display("FAIL stuffviol_rcv: got %b want 0", receiving); end
`ifdef USB_RX_STUFF_CHECK_EN
    vectors++;
    if (serr_cnt - s0 != 1) begin miscompares++; $display("FAIL stuffviol_serr: got %0d want 1", serr_cnt - s0); end
    vectors++;
    if (eop_cnt - e0 != 0) begin miscompares++; $display("FAIL stuffviol_eop: got %0d want 0", eop_cnt - e0); end
`else
    vectors++;
    if (serr_cnt - s0 != 0) begin miscompares++; $display("FAIL stuffviol_serr: got %0d want 0", serr_cnt - s0); end
    vectors++;
    if (eop_cnt - e0 != 1) begin miscompares++; $display("FAIL stuffviol_eop: got %0d want 1", eop_cnt - e0); end
`endif
  endtask

  task automatic test_jitter();
    run_a5_3c(1'b1, "jitter");
  endtask

  task automatic test_short_and_disable();
    int b0, e0, r0;
    b0 = got_q.size();
    e0 = eop_cnt;
    q_clear();
    q_sync();
    q_data(1'b1, 1'b1);
    q_data(1'b0, 1'b1);
    q_data(1'b1, 1'b1);
    q_eop();
    play(1'b0, -1);
    vectors++;
    if (got_q.size() - b0 != 0) begin miscompares++; $display("FAIL short_bytes: got %0d want 0", got_q.size() - b0); end
    vectors++;
    if (eop_cnt - e0 != 1) begin miscompares++; $display("FAIL short_eop: got %0d want 1", eop_cnt - e0); end
    vectors++;
    if (rx_data !== 8'h3C) begin miscompares++; $display("FAIL short_rx_data_hold: got %h want 3c", rx_data); end

    rx_enable = 1'b0;
    b0 = got_q.size();
    e0 = eop_cnt;
    r0 = rcv_cycles;
    q_clear();
    q_sync();
    q_byte(8'h55);
    q_eop();
    play(1'b0, -1);
    rx_enable = 1'b1;
    vectors++;
    if (rcv_cycles - r0 != 0) begin miscompares++; $display("FAIL disabled_rcv: got %0d cycles want 0", rcv_cycles - r0); end
    vectors++;
    if ((got_q.size() - b0) + (eop_cnt - e0) != 0) begin
      miscompares++;
      $display("FAIL disabled_pulses: got bytes=%0d eop=%0d want 0", got_q.size() - b0, eop_cnt - e0);
    end
  endtask

  initial begin
    test_reset();
    test_two_bytes();
    test_stuffed_bytes();
    test_reset_mid_data();
    test_stuff_violation();
    test_jitter();
    test_short_and_disable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
